// File: rtl/clk_period_meter.sv
// clk_period_meter
//
// Measures the period of a slow asynchronous periodic signal in cycles of the
// fast system clock. The signal is synchronized through three flops, rising
// edges are detected, and the clk cycles between consecutive rising edges are
// counted. The result is presented with a valid/ack handshake; a counter that
// saturates (stuck or too-slow input) ends the measurement with ovf set.
//
// Optional feature macro: PERIOD_AVG_EN
//   When defined, four consecutive periods are measured and their truncated
//   average is reported. When undefined, a single period is measured and no
//   accumulator exists.
//
// Ports:
//   clk     in   system clock, rising edge
//   reset   in   asynchronous active-low reset
//   sig_in  in   signal under measurement, asynchronous to clk
//   start   in   single-cycle measurement request (honoured only in IDLE)
//   ack     in   result acknowledge (honoured only in DONE)
//   busy    out  high from accepted start until return to IDLE
//   valid   out  result available, held until ack
//   period  out  measured period in clk cycles (all-ones on overflow)
//   ovf     out  measurement saturated

module clk_period_meter #(
  parameter int unsigned CNT_W = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sig_in,
  input  logic             start,
  input  logic             ack,
  output logic             busy,
  output logic             valid,
  output logic [CNT_W-1:0] period,
  output logic             ovf
);

  typedef enum logic [1:0] {StIdle, StArm, StMeas, StDone} state_e;

  localparam logic [CNT_W-1:0] CntMax = '1;
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  state_e           state_q;
  logic             s1_q, s2_q, s3_q;
  logic [CNT_W-1:0] cnt_q;
  logic             rise;
  logic             cnt_sat;

  // s1/s2 form the metastability synchronizer; s3 delays s2 for edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= sig_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign rise    = s2_q & ~s3_q;
  assign cnt_sat = (cnt_q == CntMax);

`ifdef PERIOD_AVG_EN
  logic [CNT_W+1:0] sum_q;
  logic [CNT_W+1:0] sum_next;
  logic [1:0]       nper_q;  // completed periods so far in this measurement

  assign sum_next = sum_q + {2'b00, cnt_q};
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      period  <= '0;
      ovf     <= 1'b0;
      valid   <= 1'b0;
      busy    <= 1'b0;
`ifdef PERIOD_AVG_EN
      sum_q   <= '0;
      nper_q  <= '0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            cnt_q   <= '0;
            busy    <= 1'b1;
            state_q <= StArm;
`ifdef PERIOD_AVG_EN
            sum_q   <= '0;
            nper_q  <= '0;
`endif
          end
        end

        StArm: begin
          if (rise) begin
            cnt_q   <= CntOne;
            state_q <= StMeas;
          end else if (cnt_sat) begin
            period  <= CntMax;
            ovf     <= 1'b1;
            valid   <= 1'b1;
            state_q <= StDone;
          end else begin
            cnt_q <= cnt_q + CntOne;
          end
        end

        StMeas: begin
          if (rise) begin
`ifdef PERIOD_AVG_EN
            if (nper_q == 2'd3) begin
              period  <= sum_next[CNT_W+1:2];
              ovf     <= 1'b0;
              valid   <= 1'b1;
              state_q <= StDone;
            end else begin
              sum_q  <= sum_next;
              nper_q <= nper_q + 2'd1;
              cnt_q  <= CntOne;
            end
`else
            period  <= cnt_q;
            ovf     <= 1'b0;
            valid   <= 1'b1;
            state_q <= StDone;
`endif
          end else if (cnt_sat) begin
            period  <= CntMax;
            ovf     <= 1'b1;
            valid   <= 1'b1;
            state_q <= StDone;
          end else begin
            cnt_q <= cnt_q + CntOne;
          end
        end

        StDone: begin
          // start coincident with ack is dropped; a new start is taken in IDLE
          if (ack) begin
            valid   <= 1'b0;
            busy    <= 1'b0;
            state_q <= StIdle;
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
